// File: rtl/led_pattern_gen.sv
// Status-LED pattern generator: a prescaled step tick drives binary count, PWM breathe,
// one-hot chase or off patterns; a per-channel enable mask gates the registered LED drive.
module led_pattern_gen #(
    parameter int CHANNELS = 3,
    parameter int PRESCALE = 6250000,
    parameter int PWM_BITS = 8
) (
    input  logic                SYSCLK,
    input  logic                RESET_N,
    input  logic [1:0]          MODE,
    input  logic [CHANNELS-1:0] EN_MASK,
    output logic [CHANNELS-1:0] LED,
    output logic                STEP
);

    // state        | meaning
    // MODE_BIN     | LEDs show a binary up-counter advanced per tick
    // MODE_BREATHE | all LEDs PWM'd with a triangle brightness ramp
    // MODE_CHASE   | single lit LED rotating left per tick
    // MODE_OFF     | LEDs dark, tick and STEP still running
    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int                  PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;

    logic [PW-1:0]       presc,   presc_d;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_d;
    logic [CHANNELS-1:0] cnt,     cnt_d;
    logic [PWM_BITS-1:0] level,   level_d;
    dir_t                dir,     dir_d;
    logic [CHANNELS-1:0] ring,    ring_d;
    mode_t               mode_q,  mode_d;
    logic [CHANNELS-1:0] raw;
    logic                restart;
    logic                tick;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc   <= '0;
            pwm_cnt <= '0;
            cnt     <= '0;
            level   <= '0;
            dir     <= DIR_UP;
            ring    <= CHANNELS'(1);
            mode_q  <= MODE_BIN;
            LED     <= '0;
            STEP    <= 1'b0;
        end else begin
            presc   <= presc_d;
            pwm_cnt <= pwm_cnt_d;
            cnt     <= cnt_d;
            level   <= level_d;
            dir     <= dir_d;
            ring    <= ring_d;
            mode_q  <= mode_d;
            LED     <= raw & EN_MASK;
            STEP    <= tick;
        end
    end

    always_comb begin
        presc_d   = presc;
        pwm_cnt_d = pwm_cnt + PWM_BITS'(1);
        cnt_d     = cnt;
        level_d   = level;
        dir_d     = dir;
        ring_d    = ring;
        mode_d    = mode_q;
        raw       = '0;

        // A mode switch spends its edge re-initialising, so it never takes a tick.
        restart = (MODE != mode_q);
        tick    = !restart && (presc == PRESC_LAST);

        if (restart) begin
            presc_d = '0;
            cnt_d   = '0;
            level_d = '0;
            dir_d   = DIR_UP;
            ring_d  = CHANNELS'(1);
            mode_d  = mode_t'(MODE);
        end else begin
            presc_d = tick ? '0 : presc + PW'(1);
            if (tick) begin
                case (mode_q)
                    MODE_BIN: cnt_d = cnt + CHANNELS'(1);
                    MODE_BREATHE: begin
                        if (dir == DIR_UP) begin
                            if (level == LVL_MAX) begin
                                dir_d   = DIR_DOWN;
                                level_d = LVL_MAX - PWM_BITS'(1);
                            end else begin
                                level_d = level + PWM_BITS'(1);
                            end
                        end else begin
                            if (level == '0) begin
                                dir_d   = DIR_UP;
                                level_d = PWM_BITS'(1);
                            end else begin
                                level_d = level - PWM_BITS'(1);
                            end
                        end
                    end
                    MODE_CHASE: ring_d = {ring[CHANNELS-2:0], ring[CHANNELS-1]};
                    default: ;
                endcase
            end
        end

        case (mode_q)
            MODE_BIN:     raw = cnt;
            MODE_BREATHE: raw = {CHANNELS{pwm_cnt < level}};
            MODE_CHASE:   raw = ring;
            default:      raw = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at PRESCALE=4, PWM_BITS=3, CHANNELS=3: windowed
// vector table for count/chase/off plus hand sequences for restart, async reset and breathe.
module tb_led_pattern_gen;

    logic       SYSCLK = 1'b0;
    logic       RESET_N;
    logic [1:0] MODE;
    logic [2:0] EN_MASK;
    logic [2:0] LED;
    logic       STEP;

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    always #5 SYSCLK = ~SYSCLK;

    led_pattern_gen #(.CHANNELS(3), .PRESCALE(4), .PWM_BITS(3)) dut (
        .SYSCLK  (SYSCLK),
        .RESET_N (RESET_N),
        .MODE    (MODE),
        .EN_MASK (EN_MASK),
        .LED     (LED),
        .STEP    (STEP)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] mask;
        logic [2:0] led;
    } vec_t;

    vec_t tbl [23];
    int   lv  [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One rising edge, then park on the falling edge for sampling and driving.
    task automatic edge_tick();
        @(posedge SYSCLK);
        ecount++;
        @(negedge SYSCLK);
    endtask

    // Four edges of one step: LED constant, STEP only on the last edge.
    task automatic run_window(input logic [2:0] exp_led, input string tag);
        for (int i = 0; i < 4; i++) begin
            edge_tick();
            check($sformatf("%s led c%0d", tag, i), 32'(LED), 32'(exp_led));
            check($sformatf("%s step c%0d", tag, i), 32'(STEP), (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_mode(input logic [1:0] m, input string tag);
        MODE = m;
        edge_tick();
        check($sformatf("%s restart step", tag), 32'(STEP), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] cur_mode;
        logic [2:0] exp;

        // binary count after reset
        tbl[0]  = '{2'd0, 3'b111, 3'd0};
        tbl[1]  = '{2'd0, 3'b111, 3'd1};
        tbl[2]  = '{2'd0, 3'b111, 3'd2};
        tbl[3]  = '{2'd0, 3'b111, 3'd3};
        tbl[4]  = '{2'd0, 3'b111, 3'd4};
        tbl[5]  = '{2'd0, 3'b111, 3'd5};
        tbl[6]  = '{2'd0, 3'b111, 3'd6};
        tbl[7]  = '{2'd0, 3'b111, 3'd7};
        tbl[8]  = '{2'd0, 3'b111, 3'd0};
        // chase, with a mask change that hides bit 1 without moving the ring
        tbl[9]  = '{2'd2, 3'b111, 3'b001};
        tbl[10] = '{2'd2, 3'b111, 3'b010};
        tbl[11] = '{2'd2, 3'b111, 3'b100};
        tbl[12] = '{2'd2, 3'b111, 3'b001};
        tbl[13] = '{2'd2, 3'b101, 3'b000};
        tbl[14] = '{2'd2, 3'b101, 3'b100};
        tbl[15] = '{2'd2, 3'b101, 3'b001};
        tbl[16] = '{2'd2, 3'b111, 3'b010};
        // off: dark, STEP still pulsing
        tbl[17] = '{2'd3, 3'b111, 3'b000};
        tbl[18] = '{2'd3, 3'b111, 3'b000};
        tbl[19] = '{2'd3, 3'b111, 3'b000};
        // back to binary: count restarts from zero
        tbl[20] = '{2'd0, 3'b111, 3'd0};
        tbl[21] = '{2'd0, 3'b111, 3'd1};
        tbl[22] = '{2'd0, 3'b111, 3'd2};

        lv = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        RESET_N = 1'b0;
        MODE    = 2'd0;
        EN_MASK = 3'b111;
        repeat (3) @(negedge SYSCLK);
        check("reset led", 32'(LED), 32'd0);
        check("reset step", 32'(STEP), 32'd0);
        RESET_N = 1'b1;
        ecount  = 0;

        cur_mode = 2'd0;
        for (int v = 0; v < 23; v++) begin
            if (tbl[v].mode != cur_mode) begin
                do_mode(tbl[v].mode, $sformatf("vec%0d", v));
                cur_mode = tbl[v].mode;
            end
            EN_MASK = tbl[v].mask;
            run_window(tbl[v].led, $sformatf("vec%0d", v));
        end

        // async reset in the middle of a chase, just after a STEP edge
        do_mode(2'd2, "pre-reset");
        run_window(3'b001, "pre-reset w0");
        run_window(3'b010, "pre-reset w1");
        RESET_N = 1'b0;
        #1;
        check("async reset led", 32'(LED), 32'd0);
        check("async reset step", 32'(STEP), 32'd0);
        MODE = 2'd0;
        repeat (2) @(negedge SYSCLK);
        RESET_N = 1'b1;
        ecount  = 0;
        run_window(3'd0, "post-reset w0");
        run_window(3'd1, "post-reset w1");
        run_window(3'd2, "post-reset w2");

        // switch to chase on the cycle where presc sits at its last value
        for (int i = 0; i < 3; i++) begin
            edge_tick();
            check($sformatf("pre-switch led c%0d", i), 32'(LED), 32'd3);
            check($sformatf("pre-switch step c%0d", i), 32'(STEP), 32'd0);
        end
        MODE = 2'd2;
        edge_tick();
        check("switch edge step suppressed", 32'(STEP), 32'd0);
        check("switch edge led", 32'(LED), 32'd3);
        run_window(3'b001, "post-switch w0");
        run_window(3'b010, "post-switch w1");
        do_mode(2'd0, "back-to-bin");
        run_window(3'd0, "back-to-bin w0");
        run_window(3'd1, "back-to-bin w1");

        // breathe: LED high exactly while pwm phase (edge-1 mod 8) < level
        do_mode(2'd1, "breathe");
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 4; i++) begin
                edge_tick();
                exp = (((ecount - 1) % 8) < lv[w]) ? 3'b111 : 3'b000;
                check($sformatf("breathe lvl%0d w%0d c%0d led", lv[w], w, i), 32'(LED), 32'(exp));
                check($sformatf("breathe w%0d c%0d step", w, i), 32'(STEP),
                      (i == 3) ? 32'd1 : 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED pattern generator driving the board's discrete status LEDs from `SYSCLK`. A programmable prescaler produces a step tick. Four runtime-selectable modes are driven from that tick: binary count, PWM breathe, one-hot chase, and off. A per-channel enable mask gates every output. It is the standard heartbeat/status indicator for all cores.

## Interface

Parameters:
- `CHANNELS`, default 3: number of LED outputs (≥2).
- `PRESCALE`, default 6250000: `SYSCLK` cycles per step tick (≥2).
- `PWM_BITS`, default 8: breathe brightness and PWM counter width (≥2). MAX = 2^PWM_BITS−1.

Ports:
- `SYSCLK`, in, 1: sole clock; all state on rising edge.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `MODE`, in, 2: 0 = binary count, 1 = breathe, 2 = chase, 3 = off.
- `EN_MASK`, in, CHANNELS: per-channel enable; 0 forces that LED low.
- `LED`, out, CHANNELS: registered LED drive, active-high.
- `STEP`, out, 1: registered one-cycle pulse per step tick.

## Operation

Reset values (RESET_N low, asynchronous):
- `presc` = 0, `pwm_cnt` = 0, `cnt` = 0, `level` = 0, `dir` = up, `ring` = 1 (bit 0 set), `mode_q` = 0.
- Outputs: `LED` = 0, `STEP` = 0.

Prescaler:
- `presc`, width clog2(PRESCALE), counts 0..PRESCALE−1, then wraps to 0.
- tick = (`presc` == PRESCALE−1).

PWM counter:
- `pwm_cnt`, PWM_BITS wide, free-running, wraps MAX→0.

Binary mode (0):
- `cnt` (CHANNELS bits) increments on tick and wraps all-ones→0.
- Raw pattern = `cnt`.

Breathe mode (1), on tick:
- Up, `level` < MAX: `level` +1.
- Up, `level` == MAX: `dir` = down, `level` = MAX−1.
- Down, `level` > 0: `level` −1.
- Down, `level` == 0: `dir` = up, `level` = 1.
- Raw pattern: every channel = (`pwm_cnt` < `level`).
- Full triangle period = 2·MAX ticks.

Chase mode (2):
- `ring` rotates left on tick; MSB wraps to bit 0.
- Raw pattern = `ring`.

Off mode (3):
- Raw pattern = 0. Prescaler and `STEP` keep running.

State and output rules:
- Each mode's state register advances on tick only while that mode is selected, and holds otherwise.
- `LED` <= raw pattern & `EN_MASK`, registered every cycle.
- Mode change: when `MODE` != `mode_q`, that cycle's edge clears `presc`, sets `cnt` = 0, `level` = 0, `dir` = up, `ring` = 1, and loads `mode_q` <= `MODE`. No tick is taken in that cycle, even if `presc` was at PRESCALE−1.
- Pattern evaluation always uses `mode_q`.
- `MODE` nonzero at reset release triggers one restart cycle. This is the normal behaviour.
- `EN_MASK` changes affect `LED` on the next edge and do not disturb any pattern state.

## Timing

- From reset release with `MODE` = 0: `presc` = k after edge k. The first tick occurs in the cycle when `presc` = PRESCALE−1.
- At edge PRESCALE: `STEP` = 1 for one cycle, and pattern state advances.
- `LED` reflects the new state one edge later (PRESCALE+1). `LED` latency = 1 cycle after the state change.
- `STEP` period = PRESCALE cycles exactly, with no drift.
- Breathe PWM period = 2^PWM_BITS cycles.
  - `level` = 0: LED constantly low.
  - `level` = MAX: LED low 1 of 2^PWM_BITS cycles.
- Asserting `RESET_N` low mid-pattern clears all outputs immediately. It does not wait for a clock edge.
- Restart after a mode change: the first tick in the new mode occurs PRESCALE cycles after the restart edge.

## Test plan

Bench parameters: PRESCALE=4, PWM_BITS=3, CHANNELS=3, `EN_MASK`=3'b111.

1. Reset, `MODE`=0.
   - `STEP` pulses every 4 cycles, first at edge 4.
   - `LED` sequence is 000, 001, 010, … 111, 000, with each value held 4 cycles.
   - `LED` lags `STEP` by 1 cycle.
2. `MODE`=2.
   - `LED` steps 001→010→100→001, each held 4 cycles.
   - Set `EN_MASK`=3'b101 mid-run: the 010 step becomes 000; the ring position is unaffected.
3. `MODE`=1.
   - `level` sequence is 0,1,…,7,6,…,0,1, giving a 14-tick period.
   - At `level`=3, each `LED` bit is high exactly 3 of every 8 cycles.
   - At `level`=0 all LEDs stay low; at `level`=7 each LED is high 7 of 8.
4. Mode change.
   - Switch 0→2 at the cycle when `presc`=3: no `STEP` that cycle, `LED` becomes 001.
   - Next `STEP` arrives 4 cycles after the switch edge.
   - Switch back to 0: `cnt` restarts at 0.
5. Assert `RESET_N` low mid-chase, asynchronously between edges.
   - `LED`=000 and `STEP`=0 immediately.
   - After release, the sequence restarts exactly as in test 1.
6. `MODE`=3: `LED` stays 000 while `STEP` keeps pulsing every 4 cycles.
